// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, the
// count-width helper and the layout of a buffered fetch entry.
package fetch_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Bits needed to hold values 0 .. value-1 (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // A buffered entry is packed {pc, data}, with pc in the upper bits.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with push/pop/flush and an occupancy count.
// The head output reads as zero while the FIFO is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [clog2(DEPTH+1)-1:0]  count_o
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & (count_q != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) count_d = count_q + 1'b1;
            if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the empty-gated head keeps stale words invisible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_seq.sv
// Self-sequencing instruction fetch: owns the PC, issues 1-cycle-latency
// memory reads under a credit check, and buffers returns for decode.
module inst_fetch_seq
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    output logic                       imem_en,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       inst_valid,
    output logic [DATA_W-1:0]          inst_data,
    output logic [ADDR_W-1:0]          inst_pc,
    input  logic                       inst_ready,
    output logic [clog2(DEPTH+1)-1:0]  buf_count
);

    localparam int CNT_W = clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
    logic              inflight_q, inflight_d;
    logic              pop, issue, push;
    logic [CNT_W:0]    occupancy;

    assign inst_valid = (buf_count != '0);
    assign pop        = inst_valid & inst_ready;

    // Credits count the word still in flight, minus the slot freed this cycle.
    assign occupancy = {1'b0, buf_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue     = run & ~redirect_valid & (occupancy < (CNT_W+1)'(DEPTH));
    assign push      = inflight_q & ~redirect_valid;

    assign imem_en   = issue & rst;
    assign imem_addr = pc_q;

    always_comb begin
        pc_d       = pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d       = pc_q + 1'b1;
            tag_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   ({tag_pc_q, imem_rdata}),
        .dout_o  ({inst_pc, inst_data}),
        .count_o (buf_count)
    );

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq: streaming, back-pressure, redirect,
// PC wrap, stall and mid-stream reset, against hand-derived cycle timing.
module tb_inst_fetch_seq;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic [2:0]        buf_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_fetch_seq #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .buf_count      (buf_count)
    );

    // Synchronous instruction memory: word = 0x1000_0000 + address.
    always_ff @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input int pc);
        check({tag, " valid"}, 64'(inst_valid), 64'd1);
        check({tag, " pc"},    64'(inst_pc),    64'(pc));
        check({tag, " data"},  64'(inst_data),  64'(32'h1000_0000 + 32'(pc)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        run            = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2;
        check("rst valid", 64'(inst_valid), 64'd0);
        check("rst count", 64'(buf_count),  64'd0);
        check("rst en",    64'(imem_en),    64'd0);
        check("rst addr",  64'(imem_addr),  64'd0);
        check("rst pc",    64'(inst_pc),    64'd0);
        check("rst data",  64'(inst_data),  64'd0);

        // Test 1: streaming from reset; release lands in cycle 0.
        step();
        rst = 1'b1;
        #1;
        check("c0 en",    64'(imem_en),    64'd1);
        check("c0 addr",  64'(imem_addr),  64'd0);
        check("c0 valid", 64'(inst_valid), 64'd0);
        step();
        check("c1 valid", 64'(inst_valid), 64'd0);
        check("c1 addr",  64'(imem_addr),  64'd1);
        for (int c = 2; c <= 7; c++) begin
            step();
            check_head("stream", c - 2);
            check("stream count", 64'(buf_count), 64'd1);
        end

        // Test 2: back-pressure for 10 cycles (cycles 8..17), head pc 6.
        step();
        inst_ready = 1'b0;
        for (int c = 8; c <= 17; c++) begin
            #1;
            check_head("hold", 6);
            if (c == 10) check("hold en off", 64'(imem_en), 64'd0);
            if (c >= 11) check("hold count", 64'(buf_count), 64'(DEPTH));
            if (c < 17) step();
        end
        step();
        inst_ready = 1'b1;
        for (int c = 18; c <= 19; c++) begin
            #1;
            check_head("resume", c - 12);
            step();
        end

        // Test 3: redirect in cycle 20 with 3 buffered and one in flight.
        #1;
        check("pre-redir count", 64'(buf_count), 64'd3);
        check_head("pre-redir", 8);
        redirect_valid = 1'b1;
        redirect_pc    = 5'd20;
        #1;
        check("redir en", 64'(imem_en), 64'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("r+1 count", 64'(buf_count), 64'd0);
        check("r+1 valid", 64'(inst_valid), 64'd0);
        check("r+1 en",    64'(imem_en),    64'd1);
        check("r+1 addr",  64'(imem_addr),  64'd20);
        step();
        check("r+2 valid", 64'(inst_valid), 64'd0);

        // Test 4: delivery from 20 through 31 and across the wrap to 1.
        for (int c = 23; c <= 36; c++) begin
            step();
            check_head("wrap", (c - 3) % 32);
        end

        // Test 5: stall for cycles 37..41.
        step();
        run = 1'b0;
        #1;
        check("stall en",  64'(imem_en), 64'd0);
        check_head("stall inflight", 2);
        step();
        check_head("stall landed", 3);
        for (int c = 39; c <= 41; c++) begin
            step();
            check("stall empty", 64'(inst_valid), 64'd0);
            check("stall en", 64'(imem_en), 64'd0);
        end
        step();
        run = 1'b1;
        #1;
        check("unstall en",   64'(imem_en),   64'd1);
        check("unstall addr", 64'(imem_addr), 64'd4);
        step();
        step();
        check_head("unstall", 4);
        step();
        check_head("unstall", 5);

        // Test 6: fill the buffer, then reset between clock edges.
        step();
        inst_ready = 1'b0;
        for (int c = 47; c <= 50; c++) step();
        check("full count", 64'(buf_count), 64'(DEPTH));
        rst = 1'b0;
        #1;
        check("async valid", 64'(inst_valid), 64'd0);
        check("async count", 64'(buf_count),  64'd0);
        check("async en",    64'(imem_en),    64'd0);
        check("async addr",  64'(imem_addr),  64'd0);
        check("async pc",    64'(inst_pc),    64'd0);
        step();
        rst        = 1'b1;
        inst_ready = 1'b1;
        #1;
        check("restart en",   64'(imem_en),   64'd1);
        check("restart addr", 64'(imem_addr), 64'd0);
        step();
        step();
        check_head("restart", 0);
        step();
        check_head("restart", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
